gpio_bus_bridge: RTL and testbench

Bus-to-register bridge sitting directly upstream of the GPIO register block. Accepts CPU memory-bus transactions (valid/ready, byte strobes) in a 256-byte window and converts them into the GPIO block's single-cycle `en`/`wr`/`addr_offset`/`data_in` strobes. It also captures the block's registered `data_out` one cycle after a read strobe. Partial-word writes are performed as read-modify-write, since the GPIO block only supports full-word writes.

---
 rtl/gpio_bus_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_gpio_bus_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_bridge.sv
// CPU memory-bus to GPIO register-block bridge: decodes a 256-byte window into
// single-cycle en/wr strobes, captures read data and performs RMW for partial writes.

module gpio_bus_bridge_checker (
    input logic clk,
    input logic resetn,
    input logic mem_ready,
    input logic gpio_en,
    input logic gpio_wr
);

    a_en_single: assert property (@(posedge clk) disable iff (!resetn) gpio_en |=> !gpio_en);
    a_ready_single: assert property (@(posedge clk) disable iff (!resetn) mem_ready |=> !mem_ready);
    a_wr_needs_en: assert property (@(posedge clk) disable iff (!resetn) gpio_wr |-> gpio_en);

endmodule

module gpio_bus_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        gpio_en,
    output logic        gpio_wr,
    output logic [7:0]  gpio_addr_offset,
    output logic [31:0] gpio_data_in,
    input  logic [31:0] gpio_data_out
);

    // The merge is folded into the RD_WAIT sample edge so the write strobe
    // lands two edges after the hit; ST_MERGE is never entered.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_MERGE   = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam logic [5:0] WORD_DATA = 6'd0;
    localparam logic [5:0] WORD_DIR  = 6'd1;
    localparam logic [5:0] WORD_IN   = 6'd2;

    state_t      state_r, state_s;
    logic        mem_ready_r, mem_ready_s;
    logic [31:0] mem_rdata_r, mem_rdata_s;
    logic        gpio_en_r, gpio_en_s;
    logic        gpio_wr_r, gpio_wr_s;
    logic [7:0]  gpio_addr_offset_r, gpio_addr_offset_s;
    logic [31:0] gpio_data_in_r, gpio_data_in_s;
    logic [31:0] wdata_r, wdata_s;
    logic [3:0]  wstrb_r, wstrb_s;
    logic        rmw_r, rmw_s;

    logic        hit_s;
    logic        req_read_s;
    logic        req_rw_s;
    logic        req_mapped_s;
    logic        unused_addr_bits_s;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign hit_s        = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign req_read_s   = (mem_wstrb == 4'h0);
    assign req_rw_s     = (mem_addr[7:2] == WORD_DATA) || (mem_addr[7:2] == WORD_DIR);
    assign req_mapped_s = req_rw_s || (mem_addr[7:2] == WORD_IN);
    assign unused_addr_bits_s = ^mem_addr[1:0];

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_s            = state_r;
        mem_ready_s        = 1'b0;
        mem_rdata_s        = mem_rdata_r;
        gpio_en_s          = 1'b0;
        gpio_wr_s          = 1'b0;
        gpio_addr_offset_s = gpio_addr_offset_r;
        gpio_data_in_s     = gpio_data_in_r;
        wdata_s            = wdata_r;
        wstrb_s            = wstrb_r;
        rmw_s              = rmw_r;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    wdata_s = mem_wdata;
                    wstrb_s = mem_wstrb;
                    rmw_s   = 1'b0;
                    if (req_read_s && req_mapped_s) begin
                        state_s            = ST_RD_REQ;
                        gpio_en_s          = 1'b1;
                        gpio_addr_offset_s = {mem_addr[7:2], 2'b00};
                    end else if (!req_read_s && req_rw_s && (mem_wstrb == 4'hF)) begin
                        state_s            = ST_WR_REQ;
                        gpio_en_s          = 1'b1;
                        gpio_wr_s          = 1'b1;
                        gpio_addr_offset_s = {mem_addr[7:2], 2'b00};
                        gpio_data_in_s     = mem_wdata;
                    end else if (!req_read_s && req_rw_s) begin
                        state_s            = ST_RD_REQ;
                        gpio_en_s          = 1'b1;
                        gpio_addr_offset_s = {mem_addr[7:2], 2'b00};
                        rmw_s              = 1'b1;
                    end else begin
                        // Unmapped access or write to the read-only input view.
                        state_s     = ST_RESP;
                        mem_ready_s = 1'b1;
                        if (req_read_s) begin
                            mem_rdata_s = 32'h0000_0000;
                        end else begin
                            mem_rdata_s = mem_rdata_r;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                state_s = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (rmw_r) begin
                    state_s        = ST_WR_REQ;
                    gpio_en_s      = 1'b1;
                    gpio_wr_s      = 1'b1;
                    gpio_data_in_s = merge_bytes(gpio_data_out, wdata_r, wstrb_r);
                end else begin
                    state_s     = ST_RESP;
                    mem_ready_s = 1'b1;
                    mem_rdata_s = gpio_data_out;
                end
            end
            ST_WR_REQ: begin
                state_s     = ST_RESP;
                mem_ready_s = 1'b1;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                rmw_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r            <= ST_IDLE;
            mem_ready_r        <= 1'b0;
            mem_rdata_r        <= 32'h0000_0000;
            gpio_en_r          <= 1'b0;
            gpio_wr_r          <= 1'b0;
            gpio_addr_offset_r <= 8'h00;
            gpio_data_in_r     <= 32'h0000_0000;
            wdata_r            <= 32'h0000_0000;
            wstrb_r            <= 4'h0;
            rmw_r              <= 1'b0;
        end else begin
            state_r            <= state_s;
            mem_ready_r        <= mem_ready_s;
            mem_rdata_r        <= mem_rdata_s;
            gpio_en_r          <= gpio_en_s;
            gpio_wr_r          <= gpio_wr_s;
            gpio_addr_offset_r <= gpio_addr_offset_s;
            gpio_data_in_r     <= gpio_data_in_s;
            wdata_r            <= wdata_s;
            wstrb_r            <= wstrb_s;
            rmw_r              <= rmw_s;
        end
    end

    assign mem_ready        = mem_ready_r;
    assign mem_rdata        = mem_rdata_r;
    assign gpio_en          = gpio_en_r;
    assign gpio_wr          = gpio_wr_r;
    assign gpio_addr_offset = gpio_addr_offset_r;
    assign gpio_data_in     = gpio_data_in_r;

    gpio_bus_bridge_checker u_checker (
        .clk       (clk),
        .resetn    (resetn),
        .mem_ready (mem_ready_r),
        .gpio_en   (gpio_en_r),
        .gpio_wr   (gpio_wr_r)
    );

endmodule

// File: tb/tb_gpio_bus_bridge.sv
// Self-checking bench for gpio_bus_bridge: emulated GPIO block, transaction-level
// expected-trace model, per-cycle compare process and directed literal checks.

module tb_gpio_bus_bridge;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        gpio_en;
    logic        gpio_wr;
    logic [7:0]  gpio_addr_offset;
    logic [31:0] gpio_data_in;
    logic [31:0] gpio_data_out;

    gpio_bus_bridge #(.BASE_ADDR(BASE)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_valid        (mem_valid),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .gpio_en          (gpio_en),
        .gpio_wr          (gpio_wr),
        .gpio_addr_offset (gpio_addr_offset),
        .gpio_data_in     (gpio_data_in),
        .gpio_data_out    (gpio_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Emulated GPIO block: registers written on en&wr, data_out registered on en&!wr.
    logic [31:0] g_data = 32'h0;
    logic [31:0] g_dir  = 32'h0;
    logic [31:0] g_dout = 32'h0;
    logic [31:0] pins   = 32'h0;
    assign gpio_data_out = g_dout;

    always @(posedge clk) begin
        if (gpio_en && gpio_wr) begin
            if (gpio_addr_offset == 8'h00) g_data <= gpio_data_in;
            else if (gpio_addr_offset == 8'h04) g_dir <= gpio_data_in;
        end else if (gpio_en) begin
            case (gpio_addr_offset)
                8'h00:   g_dout <= g_data;
                8'h04:   g_dout <= g_dir;
                8'h08:   g_dout <= pins;
                default: g_dout <= 32'h0;
            endcase
        end
    end

    // Expected per-cycle output trace; an empty queue means an idle cycle.
    typedef struct {
        logic        ready;
        logic        en;
        logic        wr;
        logic        set_off;
        logic [7:0]  off;
        logic        set_din;
        logic [31:0] din;
        logic        set_rd;
        logic [31:0] rd;
    } rec_t;

    rec_t exp_q[$];
    logic [31:0] m_data = 32'h0;
    logic [31:0] m_dir  = 32'h0;

    function automatic rec_t blank();
        rec_t r;
        r.ready = 1'b0; r.en = 1'b0; r.wr = 1'b0;
        r.set_off = 1'b0; r.off = 8'h00;
        r.set_din = 1'b0; r.din = 32'h0;
        r.set_rd = 1'b0;  r.rd = 32'h0;
        return r;
    endfunction

    function automatic rec_t zero_rec();
        rec_t r;
        r = blank();
        r.set_off = 1'b1; r.set_din = 1'b1; r.set_rd = 1'b1;
        return r;
    endfunction

    task automatic model_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        rec_t r;
        logic [5:0]  word;
        logic [31:0] old, merged;
        bit rd;
        if (addr[31:8] != BASE[31:8]) return;
        word = addr[7:2];
        rd = (wstrb == 4'h0);
        exp_q.push_back(blank());
        if (rd && word <= 6'd2) begin
            r = blank(); r.en = 1'b1; r.set_off = 1'b1; r.off = {word, 2'b00};
            exp_q.push_back(r);
            exp_q.push_back(blank());
            r = blank(); r.ready = 1'b1; r.set_rd = 1'b1;
            r.rd = (word == 6'd0) ? m_data : (word == 6'd1) ? m_dir : pins;
            exp_q.push_back(r);
        end else if (!rd && word <= 6'd1) begin
            old = (word == 6'd0) ? m_data : m_dir;
            for (int i = 0; i < 4; i++)
                merged[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
            if (wstrb != 4'hF) begin
                r = blank(); r.en = 1'b1; r.set_off = 1'b1; r.off = {word, 2'b00};
                exp_q.push_back(r);
                exp_q.push_back(blank());
            end
            r = blank(); r.en = 1'b1; r.wr = 1'b1; r.set_off = 1'b1; r.off = {word, 2'b00};
            r.set_din = 1'b1; r.din = merged;
            exp_q.push_back(r);
            r = blank(); r.ready = 1'b1;
            exp_q.push_back(r);
            if (word == 6'd0) m_data = merged; else m_dir = merged;
        end else begin
            r = blank(); r.ready = 1'b1;
            if (rd) begin r.set_rd = 1'b1; r.rd = 32'h0; end
            exp_q.push_back(r);
        end
    endtask

    // Per-cycle compare of every DUT output against the expected trace.
    bit          chk_on = 1'b0;
    rec_t        cur;
    logic [7:0]  last_off = 8'h00;
    logic [31:0] last_din = 32'h0;
    logic [31:0] last_rd  = 32'h0;

    always @(negedge clk) begin
        if (chk_on) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = blank();
            if (cur.set_off) last_off = cur.off;
            if (cur.set_din) last_din = cur.din;
            if (cur.set_rd)  last_rd  = cur.rd;
            check("cyc_mem_ready", {31'h0, mem_ready}, {31'h0, cur.ready});
            check("cyc_gpio_en",   {31'h0, gpio_en},   {31'h0, cur.en});
            check("cyc_gpio_wr",   {31'h0, gpio_wr},   {31'h0, cur.wr});
            check("cyc_offset",    {24'h0, gpio_addr_offset}, {24'h0, last_off});
            check("cyc_data_in",   gpio_data_in, last_din);
            check("cyc_mem_rdata", mem_rdata, last_rd);
        end
    end

    // Starts at posedge+1 and returns at posedge+1 with mem_valid low.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input bit drop_early, output int ready_k, output logic [31:0] rdata,
                          output logic [31:0] wr_data, output int n_en);
        bit hit, done;
        hit = (addr[31:8] == BASE[31:8]);
        ready_k = -1; rdata = 32'h0; wr_data = 32'h0; n_en = 0; done = 1'b0;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        model_txn(addr, wdata, wstrb);
        for (int k = 0; k <= 10 && !done; k++) begin
            @(negedge clk);
            if (gpio_en) n_en++;
            if (gpio_en && gpio_wr) wr_data = gpio_data_in;
            if (mem_ready) begin
                ready_k = k; rdata = mem_rdata; done = 1'b1;
            end else if (drop_early && hit && k == 1) begin
                mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
            end
        end
        if (hit) check("ready_seen", {31'h0, done}, 32'h1);
        else     check("miss_no_ready", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    int          rk, nen, sel, gap;
    logic [31:0] rdat, wdat, a, wd;
    logic [3:0]  ws;
    bit          drop;

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_gpio_en",   {31'h0, gpio_en}, 32'h0);
        check("rst_gpio_wr",   {31'h0, gpio_wr}, 32'h0);
        check("rst_offset",    {24'h0, gpio_addr_offset}, 32'h0);
        check("rst_data_in",   gpio_data_in, 32'h0);
        @(posedge clk); #1;
        chk_on = 1'b1;

        do_txn(BASE + 32'h4, 32'h0000_00FF, 4'hF, 1'b0, rk, rdat, wdat, nen);
        check("wr_full_latency", rk, 32'd2);
        check("wr_full_strobes", nen, 32'd1);
        check("wr_full_data", wdat, 32'h0000_00FF);
        do_txn(BASE + 32'h4, 32'h0, 4'h0, 1'b0, rk, rdat, wdat, nen);
        check("rd_dir_data", rdat, 32'h0000_00FF);
        check("rd_dir_latency", rk, 32'd3);

        do_txn(BASE, 32'hA5A5_A5A5, 4'hF, 1'b0, rk, rdat, wdat, nen);
        do_txn(BASE, 32'h0, 4'h0, 1'b0, rk, rdat, wdat, nen);
        check("rd_data_value", rdat, 32'hA5A5_A5A5);
        check("rd_data_latency", rk, 32'd3);
        check("rd_data_strobes", nen, 32'd1);

        do_txn(BASE, 32'h1122_3344, 4'hF, 1'b0, rk, rdat, wdat, nen);
        do_txn(BASE, 32'hAABB_CCDD, 4'b0101, 1'b0, rk, rdat, wdat, nen);
        check("rmw_merged", wdat, 32'h11BB_33DD);
        check("rmw_latency", rk, 32'd4);
        check("rmw_strobes", nen, 32'd2);
        do_txn(BASE, 32'h0, 4'h0, 1'b0, rk, rdat, wdat, nen);
        check("rmw_readback", rdat, 32'h11BB_33DD);

        do_txn(BASE + 32'h10, 32'h0, 4'h0, 1'b0, rk, rdat, wdat, nen);
        check("unmapped_rdata", rdat, 32'h0);
        check("unmapped_latency", rk, 32'd1);
        check("unmapped_strobes", nen, 32'd0);
        do_txn(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 1'b0, rk, rdat, wdat, nen);
        check("ro_write_strobes", nen, 32'd0);
        check("ro_write_latency", rk, 32'd1);

        do_txn(BASE + 32'h100, 32'h0, 4'h0, 1'b0, rk, rdat, wdat, nen);
        check("miss_ready_k", rk, 32'hFFFF_FFFF);
        check("miss_strobes", nen, 32'd0);

        // Reset while the read waits for gpio_data_out.
        mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        model_txn(BASE, 32'h0, 4'h0);
        void'(exp_q.pop_back());
        exp_q.push_back(zero_rec());
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {31'h0, mem_ready}, 32'h0);
        check("mid_rst_en", {31'h0, gpio_en}, 32'h0);
        check("mid_rst_data_in", gpio_data_in, 32'h0);
        @(posedge clk); #1;
        pins = 32'hCAFE_0001;
        do_txn(BASE + 32'h8, 32'h0, 4'h0, 1'b0, rk, rdat, wdat, nen);
        check("post_rst_read", rdat, 32'hCAFE_0001);
        check("post_rst_latency", rk, 32'd3);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 12) begin
                a = $urandom;
                if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
                if (sel < 4) a = BASE + 32'h100 + 32'($urandom_range(0, 255));
                else if (sel < 7) a = BASE - 32'd4;
            end else begin
                case ($urandom_range(0, 3))
                    0: a = BASE | 32'h0;
                    1: a = BASE | 32'h4;
                    2: a = BASE | 32'h8;
                    default: a = BASE | 32'($urandom_range(0, 255));
                endcase
                a[1:0] = 2'($urandom);
            end
            sel = $urandom_range(0, 9);
            if (sel < 4) ws = 4'h0;
            else if (sel < 7) ws = 4'hF;
            else ws = 4'($urandom_range(1, 14));
            wd = $urandom;
            pins = $urandom;
            drop = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            do_txn(a, wd, ws, drop, rk, rdat, wdat, nen);
        end

        repeat (3) @(posedge clk);
        #1;
        check("trace_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
